// File: rtl/score_board_mux.sv
// N-team scoreboard: saturating signed point commands with one-level undo,
// a round-robin double-dabble BCD converter and a multiplexed 7-segment scan.
module score_board_mux #(
  parameter int N_TEAMS   = 2,
  parameter int DIGITS    = 3,
  parameter int SCORE_W   = 10,
  parameter int MAX_SCORE = 999,
  parameter int SCAN_DIV  = 1000,
  localparam int TW       = (N_TEAMS > 1) ? $clog2(N_TEAMS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          cmd_valid,
  input  logic [TW-1:0]                 cmd_team,
  input  logic                          cmd_sub,
  input  logic [1:0]                    cmd_pts,
  input  logic                          undo,
  input  logic                          blank_lz,
  output logic [N_TEAMS*SCORE_W-1:0]    score_flat,
  output logic                          sat,
  output logic                          undo_ok,
  output logic [7:0]                    seg,
  output logic [N_TEAMS*DIGITS-1:0]     an
);

  localparam int NDIG  = N_TEAMS * DIGITS;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int SH_W  = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam int EXT_W = SCORE_W + 2;

  localparam logic [TW:0]       TEAM_LIM = (TW + 1)'(N_TEAMS);
  localparam logic [EXT_W-1:0]  MAX_EXT  = EXT_W'(MAX_SCORE);
  localparam logic [NDIG-1:0]   AN_ONE   = NDIG'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} conv_state_t;

  logic [SCORE_W-1:0] score [N_TEAMS];
  logic               hist_valid;
  logic [TW-1:0]      hist_team;
  logic [SCORE_W-1:0] hist_score;

  logic               accept;
  logic               clamped;
  logic [SCORE_W-1:0] old_score;
  logic [SCORE_W-1:0] new_score;
  logic [EXT_W-1:0]   ext_old;
  logic [EXT_W-1:0]   ext_sum;
  logic [EXT_W-1:0]   ext_diff;

  conv_state_t        state;
  logic [TW-1:0]      conv_team;
  logic [SCORE_W-1:0] conv_bin;
  logic [BCD_W-1:0]   conv_bcd;
  logic [SH_W-1:0]    shift_cnt;
  logic [SCORE_W-1:0] snap_score;
  logic [BCD_W-1:0]   bcd_cache [N_TEAMS];

  logic [CNT_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]   scan_idx;
  logic [TW-1:0]      scan_team;
  logic [DIG_W-1:0]   scan_digit;
  logic [BCD_W-1:0]   team_bcd;
  logic [3:0]         nibble;
  logic               upper_zero;
  logic [7:0]         seg_next;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [BCD_W+SCORE_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                          input logic [SCORE_W-1:0] bin);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

  // Widened arithmetic so neither the ceiling nor the floor can wrap.
  always_comb begin
    old_score = '0;
    for (int i = 0; i < N_TEAMS; i++) begin
      if (cmd_team == TW'(i)) old_score = score[i];
    end
    ext_old   = {2'b00, old_score};
    ext_sum   = ext_old + EXT_W'(cmd_pts);
    ext_diff  = ext_old - EXT_W'(cmd_pts);
    new_score = old_score;
    clamped   = 1'b0;
    if (cmd_sub) begin
      if (ext_diff[EXT_W-1]) begin
        new_score = '0;
        clamped   = 1'b1;
      end else begin
        new_score = ext_diff[SCORE_W-1:0];
      end
    end else if (ext_sum > MAX_EXT) begin
      new_score = SCORE_W'(MAX_SCORE);
      clamped   = 1'b1;
    end else begin
      new_score = ext_sum[SCORE_W-1:0];
    end
  end

  assign accept = cmd_valid && (cmd_pts != 2'd0) && ({1'b0, cmd_team} < TEAM_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TEAMS; i++) score[i] <= '0;
      hist_valid <= 1'b0;
      hist_team  <= '0;
      hist_score <= '0;
      sat        <= 1'b0;
      undo_ok    <= 1'b0;
    end else begin
      sat     <= 1'b0;
      undo_ok <= 1'b0;
      if (clr) begin
        for (int i = 0; i < N_TEAMS; i++) score[i] <= '0;
        hist_valid <= 1'b0;
      end else if (accept) begin
        for (int i = 0; i < N_TEAMS; i++) begin
          if (cmd_team == TW'(i)) score[i] <= new_score;
        end
        hist_team  <= cmd_team;
        hist_score <= old_score;
        hist_valid <= 1'b1;
        sat        <= clamped;
      end else if (undo && hist_valid) begin
        for (int i = 0; i < N_TEAMS; i++) begin
          if (hist_team == TW'(i)) score[i] <= hist_score;
        end
        hist_valid <= 1'b0;
        undo_ok    <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_TEAMS; g++) begin : g_flat
    assign score_flat[g*SCORE_W +: SCORE_W] = score[g];
  end

  always_comb begin
    snap_score = '0;
    for (int i = 0; i < N_TEAMS; i++) begin
      if (conv_team == TW'(i)) snap_score = score[i];
    end
  end

  // The snapshot taken in LOAD is private, so later score edits wait for the next pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      conv_team <= '0;
      conv_bin  <= '0;
      conv_bcd  <= '0;
      shift_cnt <= '0;
      for (int i = 0; i < N_TEAMS; i++) bcd_cache[i] <= '0;
    end else begin
      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          conv_bin  <= snap_score;
          conv_bcd  <= '0;
          shift_cnt <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          {conv_bcd, conv_bin} <= dabble_step(conv_bcd, conv_bin);
          shift_cnt <= shift_cnt + SH_W'(1);
          if (shift_cnt == SH_W'(SCORE_W - 1)) state <= STORE;
        end
        STORE: begin
          for (int i = 0; i < N_TEAMS; i++) begin
            if (conv_team == TW'(i)) bcd_cache[i] <= conv_bcd;
          end
          conv_team <= (conv_team == TW'(N_TEAMS - 1)) ? '0 : conv_team + TW'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    team_bcd = '0;
    for (int i = 0; i < N_TEAMS; i++) begin
      if (scan_team == TW'(i)) team_bcd = bcd_cache[i];
    end
    nibble     = 4'd0;
    upper_zero = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (scan_digit == DIG_W'(d)) nibble = team_bcd[d*4 +: 4];
      if ((DIG_W'(d) >= scan_digit) && (team_bcd[d*4 +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    if (blank_lz && (scan_digit != '0) && upper_zero) seg_next = 8'hFF;
    else                                               seg_next = seg_decode(nibble);
  end

  // seg and an come from the same scan state on the same edge, so they always pair up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt   <= '0;
      scan_idx   <= '0;
      scan_team  <= '0;
      scan_digit <= '0;
      seg        <= 8'hFF;
      an         <= '1;
    end else begin
      seg <= seg_next;
      an  <= ~(AN_ONE << scan_idx);
      if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        if (scan_idx == IDX_W'(NDIG - 1)) begin
          scan_idx   <= '0;
          scan_team  <= '0;
          scan_digit <= '0;
        end else begin
          scan_idx <= scan_idx + IDX_W'(1);
          if (scan_digit == DIG_W'(DIGITS - 1)) begin
            scan_digit <= '0;
            scan_team  <= scan_team + TW'(1);
          end else begin
            scan_digit <= scan_digit + DIG_W'(1);
          end
        end
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/score_board_mux.md
# score_board_mux

Parametrised N-team scoreboard core, the next generation of the two-team key-driven 7-segment scoreboard. It accepts signed 1/2/3-point commands per team with saturation and a one-level undo. A sequential double-dabble engine converts each score to BCD, and a time-multiplexed active-low 7-segment scan drives all team digits from one segment bus. It sits between the debounced key/command decoder and the board's common-segment display pins.

## Interface
- N_TEAMS, 2, number of teams (1..8); TW = max(1, clog2(N_TEAMS))
- DIGITS, 3, decimal digits displayed per team (1..4)
- SCORE_W, 10, binary score width; MAX_SCORE < 2**SCORE_W required
- MAX_SCORE, 999, saturation ceiling; MAX_SCORE < 10**DIGITS required
- SCAN_DIV, 1000, clocks each digit is held during scan (>=2)
- clk  in  1  system clock, all state rising-edge
- rst  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: all scores to 0, undo history invalidated
- cmd_valid  in  1  one-cycle command strobe
- cmd_team  in  TW  target team index
- cmd_sub  in  1  1 = subtract, 0 = add
- cmd_pts  in  2  points 1..3; 0 = no-op (command ignored, no history update)
- undo  in  1  one-cycle strobe: revert last accepted command
- blank_lz  in  1  1 = blank leading zeros (units digit never blanked)
- score_flat  out  N_TEAMS*SCORE_W  binary scores, team k at [k*SCORE_W +: SCORE_W]
- sat  out  1  one-cycle pulse: last command was clamped
- undo_ok  out  1  one-cycle pulse: undo performed
- seg  out  8  active-low segments {dp,g..a}, dp always 1
- an  out  N_TEAMS*DIGITS  active-low one-hot digit enable

## Operation
- Reset (rst low, asynchronous): scores 0, history invalid, sat/undo_ok 0, BCD cache 0, converter idle at team 0, scan index 0, scan counter 0, seg 8'hFF, an all 1s.
- Command accepted when cmd_valid=1 and cmd_pts!=0 and cmd_team<N_TEAMS; other commands are ignored with no side effects.
- Add: new = min(old+pts, MAX_SCORE). Subtract: new = max(old-pts, 0). Compute at SCORE_W+2 bits and never wrap. sat=1 next cycle if the result was clamped.
- History: every accepted command stores {team, old score} and sets valid, even if clamped and even if the score is unchanged.
- Undo when valid: restore the stored team's old score, clear valid, pulse undo_ok. Undo when invalid: ignored, no pulse. History depth is one; a second undo does nothing.
- Simultaneous cmd_valid and undo: the command wins and the undo is dropped. clr has priority over both.
- Converter FSM, states IDLE→LOAD→SHIFT→STORE→IDLE, looping continuously round-robin over teams 0..N_TEAMS-1.
  - LOAD: snapshot score of current team, clear BCD shift register (4*DIGITS bits).
  - SHIFT: SCORE_W cycles; each cycle add 3 to any nibble >=5, then shift left 1, MSB of score first.
  - STORE: write BCD to team cache, advance team (wrap to 0).
- A score change mid-conversion does not disturb the in-flight snapshot; it is picked up on that team's next pass.
- Scan: index k = 0..N_TEAMS*DIGITS-1, with team = k/DIGITS and digit = k%DIGITS (0 = units). Advance k every SCAN_DIV clocks, wrap to 0.
- an[k]=0 only for the current k. seg shows the decoded cache nibble: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90, others FF.
- Leading-zero blanking: with blank_lz=1, a digit above units whose nibble and all higher nibbles are 0 outputs seg=FF, with an still asserted.

## Timing
- Command/undo/clr to score_flat: 1 clock (registered). sat and undo_ok are asserted in that same cycle, for exactly 1 clock.
- One conversion = 1 (LOAD) + SCORE_W (SHIFT) + 1 (STORE) + 1 (IDLE) = SCORE_W+3 clocks.
- Score change to cache update: at most 2*N_TEAMS*(SCORE_W+3) clocks.
- seg and an are registered together: they change on the same edge and never show a mismatched digit/segment pair.
- clr mid-conversion: the converter continues, and the cache reaches 0 within the latency bound above.
- Reset deassertion: the first scan digit is enabled on the first clk edge; the first cache write occurs SCORE_W+2 clocks later.

## Test plan
- Reset then idle 2*N*(W+3) clocks -> score_flat=0, scan all 6 digits, units digits seg=C0; with blank_lz=1 tens/hundreds seg=FF.
- Team 1: add 3, add 2, add 3 -> score 8; team 0: sub 1 from 0 -> score 0, sat pulse.
- Team 0 preset to 998 via commands, add 3 -> 999 with sat=1; cache nibbles {9,9,9}; scan at k=0..2 gives 90,90,90.
- Team 1 at 8, add 2 -> 10; undo -> 8 with undo_ok=1; second undo -> no change, undo_ok=0.
- cmd (team0 +1) and undo in the same cycle -> score incremented, no undo_ok; a following undo reverts only the +1.
- Assert rst mid-SHIFT and mid-scan -> all outputs at their reset values immediately (asynchronous); clr while a command is pending -> all scores 0, undo ignored.
